// File: rtl/register_file_sb.sv
// register_file_sb: 2**ADDR_W x WIDTH register file with a per-register busy scoreboard
// Ports: clk, rst (sync, active-high); addra/addrb -> a/b read data and a_busy/b_busy;
//        we/addrw/wd write port (clears busy); rsv/addrr reserve port (sets busy);
//        busy_any = OR of all busy bits.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through forwarding to the read ports.
module register_file_sb #(
   parameter int WIDTH = 8,
   parameter int ADDR_W = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addra,
   input  logic [ADDR_W-1:0] addrb,
   output logic [WIDTH-1:0]  a,
   output logic [WIDTH-1:0]  b,
   output logic              a_busy,
   output logic              b_busy,
   input  logic              we,
   input  logic [ADDR_W-1:0] addrw,
   input  logic [WIDTH-1:0]  wd,
   input  logic              rsv,
   input  logic [ADDR_W-1:0] addrr,
   output logic              busy_any
);
   localparam int DEPTH = 2 ** ADDR_W;
   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] busy;
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
         busy <= '0;
      end else begin
         if (we) begin
            regs[addrw] <= wd;
            busy[addrw] <= 1'b0;
         end
         // Reserve comes last so a new producer wins over a retiring one.
         if (rsv) busy[addrr] <= 1'b1;
      end
   end
`ifdef REGFILE_BYPASS_EN
   logic fwd_a, fwd_b;
   always_comb begin
      fwd_a  = we && !rst && addrw == addra;
      fwd_b  = we && !rst && addrw == addrb;
      a      = fwd_a ? wd : regs[addra];
      b      = fwd_b ? wd : regs[addrb];
      a_busy = fwd_a ? (rsv && addrr == addra) : busy[addra];
      b_busy = fwd_b ? (rsv && addrr == addrb) : busy[addrb];
   end
`else
   always_comb begin
      a      = regs[addra];
      b      = regs[addrb];
      a_busy = busy[addra];
      b_busy = busy[addrb];
   end
`endif
   assign busy_any = |busy;
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: table vectors, corner sequences and a random model check for register_file_sb
module tb_register_file_sb;
   logic clk = 0, rst = 0, we = 0, rsv = 0;
   logic [1:0] addra = 0, addrb = 0, addrw = 0, addrr = 0;
   logic [7:0] wd = 0, a, b;
   logic a_busy, b_busy, busy_any;
   int errors = 0, checks = 0;

   register_file_sb dut (
      .clk(clk), .rst(rst), .addra(addra), .addrb(addrb), .a(a), .b(b),
      .a_busy(a_busy), .b_busy(b_busy), .we(we), .addrw(addrw), .wd(wd),
      .rsv(rsv), .addrr(addrr), .busy_any(busy_any)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       r, w;
      logic [1:0] aw;
      logic [7:0] d;
      logic       s;
      logic [1:0] ar, ra, rb;
      logic [7:0] ea, eb;
      logic       eab, ebb, eany;
   } vec_t;

   vec_t v [15];
   logic [7:0] m [4];
   logic [3:0] mb;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1;
`else
   localparam bit BYP = 0;
`endif

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //        r  w aw  d     s ar ra rb  ea     eb    eab ebb any
      v[0]  = '{1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0};
      v[1]  = '{1, 0, 0, 8'h00, 0, 0, 2, 3, 8'h00, 8'h00, 0, 0, 0};
      v[2]  = '{0, 1, 0, 8'h11, 0, 0, 0, 1, 8'h11, 8'h00, 0, 0, 0};
      v[3]  = '{0, 1, 1, 8'h22, 0, 0, 0, 1, 8'h11, 8'h22, 0, 0, 0};
      v[4]  = '{0, 1, 2, 8'h33, 0, 0, 2, 3, 8'h33, 8'h00, 0, 0, 0};
      v[5]  = '{0, 1, 3, 8'h44, 0, 0, 2, 3, 8'h33, 8'h44, 0, 0, 0};
      v[6]  = '{0, 0, 0, 8'h00, 0, 0, 1, 1, 8'h22, 8'h22, 0, 0, 0};
      v[7]  = '{0, 0, 0, 8'h00, 1, 2, 2, 3, 8'h33, 8'h44, 1, 0, 1};
      v[8]  = '{0, 1, 2, 8'h5A, 0, 0, 2, 0, 8'h5A, 8'h11, 0, 0, 0};
      v[9]  = '{0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h22, 8'h11, 1, 0, 1};
      v[10] = '{0, 1, 1, 8'h7E, 1, 1, 1, 1, 8'h7E, 8'h7E, 1, 1, 1};
      v[11] = '{0, 1, 3, 8'hFF, 1, 3, 3, 1, 8'hFF, 8'h7E, 1, 1, 1};
      v[12] = '{1, 1, 3, 8'h01, 1, 0, 3, 0, 8'h00, 8'h00, 0, 0, 0};
      v[13] = '{0, 1, 2, 8'h05, 0, 0, 2, 1, 8'h05, 8'h00, 0, 0, 0};
      v[14] = '{0, 1, 1, 8'h66, 1, 0, 0, 1, 8'h00, 8'h66, 1, 0, 1};

      for (int i = 0; i < 15; i++) begin
         rst = v[i].r; we = v[i].w; addrw = v[i].aw; wd = v[i].d;
         rsv = v[i].s; addrr = v[i].ar;
         step();
         rst = 0; we = 0; rsv = 0;
         addra = v[i].ra; addrb = v[i].rb;
         #1;
         chk($sformatf("vec%0d a", i), a, v[i].ea);
         chk($sformatf("vec%0d b", i), b, v[i].eb);
         chk($sformatf("vec%0d a_busy", i), a_busy, v[i].eab);
         chk($sformatf("vec%0d b_busy", i), b_busy, v[i].ebb);
         chk($sformatf("vec%0d busy_any", i), busy_any, v[i].eany);
      end

      // Same-cycle visibility of a write: forwarded only in the bypass build.
      we = 1; addrw = 0; wd = 8'h10;
      step();
      wd = 8'h99; addra = 0; addrb = 1;
      #1;
      chk("bypass a same cycle", a, BYP ? 8'h99 : 8'h10);
      chk("bypass b unaffected", b, 8'h66);
      step();
      we = 0;
      #1;
      chk("write a next cycle", a, 8'h99);

      // Forwarded port with a same-address reserve stays busy in bypass build.
      we = 1; rsv = 1; addrw = 2; addrr = 2; wd = 8'hC3; addra = 2;
      #1;
      chk("we+rsv a same cycle", a, BYP ? 8'hC3 : 8'h05);
      chk("we+rsv a_busy same cycle", a_busy, BYP ? 1'b1 : 1'b0);
      step();
      we = 0; rsv = 0;
      #1;
      chk("we+rsv a after", a, 8'hC3);
      chk("we+rsv a_busy after", a_busy, 1'b1);

      // Randomized run against an array/bitmask model.
      rst = 1;
      step();
      rst = 0;
      for (int i = 0; i < 4; i++) m[i] = 8'h00;
      mb = '0;
      for (int n = 0; n < 400; n++) begin
         logic [7:0] ea, eb;
         logic eab, ebb;
         rst = ($urandom_range(0, 31) == 0);
         we = $urandom_range(0, 1); rsv = $urandom_range(0, 2) == 0;
         addrw = 2'($urandom); addrr = 2'($urandom);
         addra = 2'($urandom); addrb = 2'($urandom);
         wd = 8'($urandom);
         #1;
         ea = m[addra]; eb = m[addrb]; eab = mb[addra]; ebb = mb[addrb];
         if (BYP && we && !rst && addrw == addra) begin
            ea = wd; eab = rsv && addrr == addra;
         end
         if (BYP && we && !rst && addrw == addrb) begin
            eb = wd; ebb = rsv && addrr == addrb;
         end
         chk("rand a", a, ea);
         chk("rand b", b, eb);
         chk("rand a_busy", a_busy, eab);
         chk("rand b_busy", b_busy, ebb);
         chk("rand busy_any", busy_any, mb != 0);
         step();
         if (rst) begin
            for (int i = 0; i < 4; i++) m[i] = 8'h00;
            mb = '0;
         end else begin
            if (we) begin
               m[addrw] = wd;
               mb[addrw] = 0;
            end
            if (rsv) mb[addrr] = 1;
         end
      end
      rst = 0; we = 0; rsv = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
